wb_sdr_arbiter: RTL and testbench

WB_SDR_ARBITER -- requirements
Module: wb_sdr_arbiter

---
 rtl/wb_sdr_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_wb_sdr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdr_arbiter.sv
// wb_sdr_arbiter: round-robin arbiter that lets two Wishbone masters share one SDRAM controller port.
// Grants are registered FSM states, and an idle cycle is always inserted between two grants.
// Optional feature: define ARB_TIMEOUT_EN to enable the stall watchdog.
// With the watchdog, a grant that stalls for TIMEOUT cycles is aborted and the master gets a one-cycle err pulse.
module wb_sdr_arbiter #(
    parameter int unsigned dw      = 32,
    parameter int unsigned APP_AW  = 26,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [APP_AW-1:0] m0_addr_i,
    input  logic [dw-1:0]     m0_dat_i,
    input  logic [dw/8-1:0]   m0_sel_i,
    input  logic [2:0]        m0_cti_i,
    output logic              m0_ack_o,
    output logic [dw-1:0]     m0_dat_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [APP_AW-1:0] m1_addr_i,
    input  logic [dw-1:0]     m1_dat_i,
    input  logic [dw/8-1:0]   m1_sel_i,
    input  logic [2:0]        m1_cti_i,
    output logic              m1_ack_o,
    output logic [dw-1:0]     m1_dat_o,
    output logic              m1_err_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [APP_AW-1:0] s_addr_o,
    output logic [dw-1:0]     s_dat_o,
    output logic [dw/8-1:0]   s_sel_o,
    output logic [2:0]        s_cti_o,
    input  logic              s_ack_i,
    input  logic [dw-1:0]     s_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;       // master granted most recently; a tie goes to the other one
    logic   timeout0_c, timeout1_c;

    // Reject watchdog limits outside the supported range at elaboration
    if (TIMEOUT < 8 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_sdr_arbiter: TIMEOUT must be within 8..65535");
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = 16;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic          stall_c;

    // Stall detection and watchdog limit check for the granted master
    always_comb begin
        stall_c    = 1'b0;
        timeout0_c = 1'b0;
        timeout1_c = 1'b0;
        if (state_q == GNT0) begin
            stall_c = m0_stb_i && !s_ack_i;
        end else if (state_q == GNT1) begin
            stall_c = m1_stb_i && !s_ack_i;
        end
        if (stall_c && (cnt_q == CW'(TIMEOUT - 1))) begin
            timeout0_c = (state_q == GNT0) && m0_cyc_i;
            timeout1_c = (state_q == GNT1) && m1_cyc_i;
        end
    end

    // Watchdog counter: counts stalled cycles and clears on ack or when the grant ends
    always_comb begin
        cnt_d  = cnt_q;
        err0_d = timeout0_c;
        err1_d = timeout1_c;
        if (state_q == IDLE || state_d == IDLE || s_ack_i) begin
            cnt_d = '0;
        end else if (stall_c) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Watchdog registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q  <= '0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            err0_q <= err0_d;
            err1_q <= err1_d;
        end
    end

    assign m0_err_o = err0_q;
    assign m1_err_o = err1_q;
`else
    assign timeout0_c = 1'b0;
    assign timeout1_c = 1'b0;
    assign m0_err_o   = 1'b0;
    assign m1_err_o   = 1'b0;
`endif

    // Next grant: idle only issues grants once SDRAM init is done; a grant lasts while its cyc stays high
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (sdr_init_done) begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (ptr_q) begin
                            state_d = GNT0;
                            ptr_d   = 1'b0;
                        end else begin
                            state_d = GNT1;
                            ptr_d   = 1'b1;
                        end
                    end else if (m0_cyc_i) begin
                        state_d = GNT0;
                        ptr_d   = 1'b0;
                    end else if (m1_cyc_i) begin
                        state_d = GNT1;
                        ptr_d   = 1'b1;
                    end
                end
            end
            GNT0: begin
                if (!m0_cyc_i || timeout0_c) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i || timeout1_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant state and round-robin pointer
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Route the granted master to the controller and the controller back to it; all zero while idle
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        unique case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_cti_o  = m0_cti_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_sdr_arbiter.sv
// tb_wb_sdr_arbiter: directed scenarios and randomized traffic, checked every cycle against a grant-ownership model.
module tb_wb_sdr_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 26;
    localparam int unsigned SW = DW / 8;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO = 16;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          init;
    logic          c[2], s[2], w[2];
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];
    logic [SW-1:0] sel[2];
    logic [2:0]    cti[2];
    logic          ack_in;
    logic [DW-1:0] sdat;

    logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic [2:0]    s_cti_o;

    // Model: owner is -1 when idle, else the master holding the grant
    int owner;
    int last;
    int stalled;
    bit err_e[2];
    bit acked[2], aborted[2];
    // Random master state
    bit busy[2], gap[2];
    int left[2];
    int gseq[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_sdr_arbiter #(
        .dw(DW), .APP_AW(AW)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .sdr_init_done(init),
        .m0_cyc_i(c[0]), .m0_stb_i(s[0]), .m0_we_i(w[0]), .m0_addr_i(a[0]),
        .m0_dat_i(d[0]), .m0_sel_i(sel[0]), .m0_cti_i(cti[0]),
        .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(c[1]), .m1_stb_i(s[1]), .m1_we_i(w[1]), .m1_addr_i(a[1]),
        .m1_dat_i(d[1]), .m1_sel_i(sel[1]), .m1_cti_i(cti[1]),
        .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_ack_i(ack_in), .s_dat_i(sdat)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare every DUT output with what the current owner implies
    task automatic check_outputs();
        bit g;
        int oi;
        g  = (owner >= 0);
        oi = g ? owner : 0;
        chk("s_cyc",  64'(s_cyc_o),  64'(g & c[oi]));
        chk("s_stb",  64'(s_stb_o),  64'(g & s[oi]));
        chk("s_we",   64'(s_we_o),   64'(g & w[oi]));
        chk("s_addr", 64'(s_addr_o), g ? 64'(a[oi])   : 64'd0);
        chk("s_dat",  64'(s_dat_o),  g ? 64'(d[oi])   : 64'd0);
        chk("s_sel",  64'(s_sel_o),  g ? 64'(sel[oi]) : 64'd0);
        chk("s_cti",  64'(s_cti_o),  g ? 64'(cti[oi]) : 64'd0);
        chk("m0_ack", 64'(m0_ack_o), 64'(owner == 0 && ack_in));
        chk("m1_ack", 64'(m1_ack_o), 64'(owner == 1 && ack_in));
        chk("m0_dat", 64'(m0_dat_o), (owner == 0) ? 64'(sdat) : 64'd0);
        chk("m1_dat", 64'(m1_dat_o), (owner == 1) ? 64'(sdat) : 64'd0);
        chk("m0_err", 64'(m0_err_o), 64'(err_e[0]));
        chk("m1_err", 64'(m1_err_o), 64'(err_e[1]));
    endtask

    // Apply the arbitration rules to the inputs present at this clock edge
    task automatic model_update();
        int o;
        o = owner;
        for (int n = 0; n < 2; n++) begin
            acked[n]   = (o == n) && s[n] && ack_in;
            aborted[n] = 1'b0;
            err_e[n]   = 1'b0;
        end
        if (rst) begin
            owner = -1; last = 1; stalled = 0;
        end else if (o < 0) begin
            if (init) begin
                if (c[0] && c[1]) owner = 1 - last;
                else if (c[0])    owner = 0;
                else if (c[1])    owner = 1;
                if (owner >= 0) last = owner;
            end
        end else if (!c[o]) begin
            owner = -1; stalled = 0;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (ack_in)    stalled = 0;
            else if (s[o]) stalled++;
            if (stalled == TO) begin
                err_e[o] = 1'b1; aborted[o] = 1'b1; owner = -1; stalled = 0;
            end
`endif
        end
    endtask

    // Check the current cycle, take the clock edge, return at the next falling edge
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            c[n] = 0; s[n] = 0; w[n] = 0; a[n] = '0; d[n] = '0; sel[n] = '0; cti[n] = '0;
            busy[n] = 0; gap[n] = 0; left[n] = 0;
        end
        ack_in = 0; sdat = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1;
        @(negedge clk);
        @(posedge clk);
        model_update();
        @(negedge clk);
        tick();
        rst = 0;
    endtask

    // Masters run bursts of acked transfers and drop cyc for one cycle afterwards
    task automatic drive_random(input bit auto_rq);
        for (int n = 0; n < 2; n++) begin
            if (acked[n] && left[n] > 0) left[n]--;
            if (busy[n] && (left[n] == 0 || aborted[n])) begin
                busy[n] = 0; gap[n] = 1;
            end else if (!busy[n]) begin
                if (gap[n]) gap[n] = 0;
                else if (auto_rq || $urandom_range(3) == 0) begin
                    busy[n] = 1;
                    left[n] = auto_rq ? 4 : int'($urandom_range(4, 1));
                end
            end
            c[n]   = busy[n];
            s[n]   = busy[n] && (auto_rq || $urandom_range(7) != 0);
            w[n]   = auto_rq ? 1'b1 : 1'($urandom_range(1));
            a[n]   = auto_rq ? ((n == 1) ? AW'(32'h200) : AW'(32'h100)) : AW'($urandom);
            d[n]   = DW'($urandom);
            sel[n] = SW'($urandom);
            cti[n] = 3'($urandom);
        end
        ack_in = auto_rq ? 1'b1 : ($urandom_range(1) == 1);
        sdat   = DW'($urandom);
        if (!auto_rq) begin
            init = ($urandom_range(7) != 0);
            rst  = ($urandom_range(63) == 0);
        end
    endtask

    initial begin
        owner = -1; last = 1; stalled = 0;
        init = 0;
        for (int n = 0; n < 2; n++) begin
            err_e[n] = 0; acked[n] = 0; aborted[n] = 0;
        end

        // No grant before SDRAM init completes, then one cycle latency
        reset_dut();
        init = 0;
        c[0] = 1; s[0] = 1; a[0] = AW'(32'h100);
        for (int i = 0; i < 20; i++) begin
            #1 chk("noinit_cyc", 64'(s_cyc_o), 64'd0);
            tick();
        end
        init = 1;
        tick();
        #1 chk("init_lat", 64'(s_cyc_o), 64'd1);

        // First tie after reset goes to m0, one idle cycle, then m1
        reset_dut();
        init = 1;
        c[0] = 1; s[0] = 1; a[0] = AW'(32'h100);
        c[1] = 1; s[1] = 1; a[1] = AW'(32'h200);
        tick();
        #1 chk("tie_gnt0", 64'(s_addr_o), 64'h100);
        c[0] = 0; s[0] = 0;
        tick();
        #1 chk("gap_idle", 64'(s_cyc_o), 64'd0);
        tick();
        #1 chk("then_gnt1", 64'(s_addr_o), 64'h200);

        // m1 read returns controller data; m0 sees nothing
        c[0] = 1; s[0] = 1;
        w[1] = 0; a[1] = AW'(32'h10);
        ack_in = 1; sdat = 32'hA5A5_A5A5;
        #1;
        chk("rd_dat", 64'(m1_dat_o), 64'hA5A5_A5A5);
        chk("rd_ack", 64'(m1_ack_o), 64'd1);
        chk("rd_m0ack", 64'(m0_ack_o), 64'd0);
        tick();

        // Reset in the middle of a GNT1 burst
        rst = 1;
        tick();
        rst = 0;
        a[0] = AW'(32'h100);
        #1;
        chk("rst_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_ack", 64'(m1_ack_o), 64'd0);
        chk("rst_dat", 64'(m1_dat_o), 64'd0);
        tick();
        #1 chk("rst_tie", 64'(s_addr_o), 64'h100);
        tick();

`ifdef ARB_TIMEOUT_EN
        // Controller never acks m0: abort after TO stalled cycles, m1 takes over
        reset_dut();
        init = 1;
        c[0] = 1; s[0] = 1; a[0] = AW'(32'h100);
        tick();
        c[1] = 1; s[1] = 1; a[1] = AW'(32'h200);
        for (int i = 0; i < int'(TO); i++) begin
            #1;
            chk("to_hold", 64'(s_cyc_o), 64'd1);
            chk("to_noerr", 64'(m0_err_o), 64'd0);
            tick();
        end
        #1;
        chk("to_err", 64'(m0_err_o), 64'd1);
        chk("to_drop", 64'(s_cyc_o), 64'd0);
        tick();
        #1;
        chk("to_gnt1", 64'(s_addr_o), 64'h200);
        chk("to_pulse", 64'(m0_err_o), 64'd0);
        tick();
`endif

        // Continuous 4-write bursts from both masters alternate grants
        reset_dut();
        init = 1;
        begin
            bit prev;
            prev = 0;
            gseq.delete();
            for (int i = 0; i < 60; i++) begin
                drive_random(1'b1);
                #1;
                if (s_cyc_o && !prev) gseq.push_back((s_addr_o == AW'(32'h200)) ? 1 : 0);
                prev = s_cyc_o;
                tick();
            end
        end
        chk("alt_count", 64'(gseq.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < gseq.size(); i++) begin
            chk("alt_order", 64'(gseq[i]), 64'(i % 2));
        end

        // Randomized traffic, random init_done and occasional resets
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            drive_random(1'b0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
